adxl345_sample_scheduler: RTL and testbench
===========================================

ADXL345_SAMPLE_SCHEDULER -- requirements
Module: adxl345_sample_scheduler

Interface
REQ-001 The block SHALL have parameter PERIOD_CYCLES, default 5000000, meaning Clk_i cycles between sample requests (>=16).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning max cycles from Start_o to Done_i.
REQ-003 The block SHALL have parameter MAX_RETRY, default 3, meaning timeouts tolerated per sample before ERROR.
REQ-004 The block SHALL have parameter AXIS_W, default 13, meaning signed axis width.
REQ-005 Clk_i  in  1  single system clock; all logic on rising edge.
REQ-006 Reset_i  in  1  reset, asynchronous, active-high.
REQ-007 Enable_i  in  1  level; 1 = periodic sampling allowed.
REQ-008 Clear_Error_i  in  1  pulse; clears ERROR state and sticky flags.
REQ-009 Start_o  out  1  one-cycle pulse requesting one burst read from the I2C controller.
REQ-010 Busy_i  in  1  I2C controller transaction in progress.
REQ-011 Done_i  in  1  one-cycle pulse; X_i/Y_i/Z_i valid this cycle.
REQ-012 X_i, Y_i, Z_i  in  AXIS_W each  signed axis samples.
REQ-013 X_o, Y_o, Z_o  out  AXIS_W each  registered last good sample.
REQ-014 Data_Available_o  out  1  one-cycle pulse, X_o/Y_o/Z_o updated.
REQ-015 Sample_Count_o  out  16  good samples captured, wraps.
REQ-016 Error_o  out  1  high while in ERROR.
REQ-017 Overrun_o  out  1  sticky; a period tick occurred while a transaction was pending.

Function
REQ-018 Period counter SHALL count 0..PERIOD_CYCLES-1 while Enable_i=1, producing a one-cycle tick at terminal count, then wrap to 0; held at 0 while Enable_i=0.
REQ-019 FSM states SHALL be IDLE, WAIT_TICK, START, WAIT_DONE, CAPTURE, ERROR.
REQ-020 IDLE -> WAIT_TICK when Enable_i=1; WAIT_TICK -> IDLE when Enable_i=0.
REQ-021 WAIT_TICK -> START on tick only if Busy_i=0; if Busy_i=1 at tick, the tick SHALL be dropped and Overrun_o set.
REQ-022 START SHALL assert Start_o for exactly one cycle, clear the timeout counter, go to WAIT_DONE.
REQ-023 WAIT_DONE: Done_i=1 -> CAPTURE, latching X_i/Y_i/Z_i that cycle.
REQ-024 WAIT_DONE: timeout counter reaching TIMEOUT_CYCLES-1 without Done_i SHALL increment retry count; retry < MAX_RETRY -> START, else -> ERROR.
REQ-025 Done_i and timeout in the same cycle: Done_i SHALL win (CAPTURE, no retry increment).
REQ-026 CAPTURE SHALL, in one cycle, drive latched values onto X_o/Y_o/Z_o, pulse Data_Available_o, increment Sample_Count_o (0xFFFF -> 0x0000), clear retry count, go to WAIT_TICK (IDLE if Enable_i=0).
REQ-027 Start-to-Data_Available_o latency SHALL be (Done_i arrival) + 1 cycle.
REQ-028 A tick occurring in START/WAIT_DONE/CAPTURE SHALL set Overrun_o and not queue a request.
REQ-029 Enable_i deasserting in START/WAIT_DONE SHALL NOT abort; transaction completes, then IDLE.
REQ-030 Done_i outside WAIT_DONE SHALL be ignored (no output change).
REQ-031 ERROR: Error_o=1, no Start_o; Clear_Error_i -> IDLE, clearing retry count, Error_o, Overrun_o.
REQ-032 Clear_Error_i outside ERROR SHALL clear only Overrun_o.

Reset
REQ-033 Reset_i=1 SHALL immediately force IDLE, all counters 0, X_o/Y_o/Z_o=0, Start_o=0, Data_Available_o=0, Error_o=0, Overrun_o=0, Sample_Count_o=0.
REQ-034 Reset mid-transaction SHALL discard the pending sample; late Done_i after release SHALL be ignored per REQ-030.

Structure
REQ-035 FSM state encodings and default PERIOD/TIMEOUT/retry constants SHALL live in the shared adxl345 parameters file.
REQ-036 One sub-module SHALL be natural: sched_period_timer (terminal-count counter with enable, used for period and timeout instances).

Verification
REQ-037 PERIOD_CYCLES=100, Done_i 20 cycles after each Start_o, X_i=-5/Y_i=12/Z_i=256 -> Start_o every 100 cycles, Data_Available_o 21 cycles after Start_o, X_o=-5, Sample_Count_o=1,2,3.
REQ-038 TIMEOUT_CYCLES=50, MAX_RETRY=3, Done_i never -> Start_o at t, t+51, t+102, Error_o=1 after third timeout; Clear_Error_i -> IDLE, Error_o=0.
REQ-039 Done_i on the same cycle as timeout terminal count -> CAPTURE, no retry, Error_o=0.
REQ-040 Busy_i=1 held across tick -> no Start_o, Overrun_o=1; Clear_Error_i -> Overrun_o=0.
REQ-041 Reset_i pulsed in WAIT_DONE, then Done_i -> all outputs 0, no Data_Available_o.
REQ-042 Preload Sample_Count_o path to 0xFFFF, one good sample -> 0x0000.

Source files
------------

// File: rtl/adxl345_sample_scheduler_pkg.sv
// Shared constants, state encoding and width helper for the ADXL345 sample scheduler.
`default_nettype none

package adxl345_sample_scheduler_pkg;

  localparam int DEFAULT_PERIOD_CYCLES  = 5000000;
  localparam int DEFAULT_TIMEOUT_CYCLES = 100000;
  localparam int DEFAULT_MAX_RETRY      = 3;
  localparam int DEFAULT_AXIS_W         = 13;
  localparam int SAMPLE_COUNT_W         = 16;
  localparam int STATE_W                = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_CAPTURE   = 3'd4,
    ST_ERROR     = 3'd5
  } sched_state_t;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/adxl345_sample_scheduler_sched_period_timer.sv
// Terminal-count counter: counts 0..TERMINAL_COUNT-1 while enabled, ticks on the last count.
`default_nettype none

module sched_period_timer
  import adxl345_sample_scheduler_pkg::*;
#(
  parameter int TERMINAL_COUNT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = cnt_width(TERMINAL_COUNT);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TERMINAL_COUNT - 1);

  logic [CNT_W-1:0] count;

  // Disabling holds the count at zero so a fresh enable always runs a full interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (count == LAST_COUNT) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = enable && (count == LAST_COUNT);

endmodule

`default_nettype wire

// File: rtl/adxl345_sample_scheduler.sv
// Periodic ADXL345 sample scheduler: issues burst-read requests, supervises timeouts/retries,
// and publishes the last good X/Y/Z sample with a running sample count.
`default_nettype none

module adxl345_sample_scheduler
  import adxl345_sample_scheduler_pkg::*;
#(
  parameter int PERIOD_CYCLES  = DEFAULT_PERIOD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int MAX_RETRY      = DEFAULT_MAX_RETRY,
  parameter int AXIS_W         = DEFAULT_AXIS_W
) (
  input  logic                      Clk_i,
  input  logic                      Reset_i,
  input  logic                      Enable_i,
  input  logic                      Clear_Error_i,
  output logic                      Start_o,
  input  logic                      Busy_i,
  input  logic                      Done_i,
  input  logic signed [AXIS_W-1:0]  X_i,
  input  logic signed [AXIS_W-1:0]  Y_i,
  input  logic signed [AXIS_W-1:0]  Z_i,
  output logic signed [AXIS_W-1:0]  X_o,
  output logic signed [AXIS_W-1:0]  Y_o,
  output logic signed [AXIS_W-1:0]  Z_o,
  output logic                      Data_Available_o,
  output logic [SAMPLE_COUNT_W-1:0] Sample_Count_o,
  output logic                      Error_o,
  output logic                      Overrun_o
);

  localparam int RETRY_W = cnt_width(MAX_RETRY + 1);

  sched_state_t state;
  sched_state_t state_next;

  logic                      period_tick;
  logic                      timeout_tick;
  logic                      timeout_run;
  logic                      start_pulse;
  logic                      capture_pulse;
  logic                      error_flag;
  logic                      retry_exhausted;
  logic                      overrun_event;
  logic                      done_accept;
  logic [RETRY_W-1:0]        retry;
  logic signed [AXIS_W-1:0]  x_sample;
  logic signed [AXIS_W-1:0]  y_sample;
  logic signed [AXIS_W-1:0]  z_sample;
  logic [SAMPLE_COUNT_W-1:0] sample_count;
  logic                      overrun;

  sched_period_timer #(
    .TERMINAL_COUNT (PERIOD_CYCLES)
  ) u_period_timer (
    .clk    (Clk_i),
    .rst    (Reset_i),
    .enable (Enable_i),
    .tick   (period_tick)
  );

  // The timeout counter only runs in WAIT_DONE, so START leaves it cleared for each attempt.
  sched_period_timer #(
    .TERMINAL_COUNT (TIMEOUT_CYCLES)
  ) u_timeout_timer (
    .clk    (Clk_i),
    .rst    (Reset_i),
    .enable (timeout_run),
    .tick   (timeout_tick)
  );

  assign retry_exhausted = (int'(retry) + 1) >= MAX_RETRY;
  assign done_accept     = (state == ST_WAIT_DONE) && Done_i;

  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (Enable_i) begin
          state_next = ST_WAIT_TICK;
        end
      end
      ST_WAIT_TICK: begin
        if (!Enable_i) begin
          state_next = ST_IDLE;
        end else if (period_tick && !Busy_i) begin
          state_next = ST_START;
        end
      end
      ST_START: begin
        state_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // A Done arriving on the timeout cycle still counts as a good sample.
        if (Done_i) begin
          state_next = ST_CAPTURE;
        end else if (timeout_tick) begin
          state_next = retry_exhausted ? ST_ERROR : ST_START;
        end
      end
      ST_CAPTURE: begin
        state_next = Enable_i ? ST_WAIT_TICK : ST_IDLE;
      end
      ST_ERROR: begin
        if (Clear_Error_i) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    start_pulse   = 1'b0;
    capture_pulse = 1'b0;
    error_flag    = 1'b0;
    timeout_run   = 1'b0;
    case (state)
      ST_START:     start_pulse   = 1'b1;
      ST_WAIT_DONE: timeout_run   = 1'b1;
      ST_CAPTURE:   capture_pulse = 1'b1;
      ST_ERROR:     error_flag    = 1'b1;
      default:      ;
    endcase
  end

  // Sample registers load on the accepting Done edge so they are already valid in CAPTURE.
  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      x_sample     <= '0;
      y_sample     <= '0;
      z_sample     <= '0;
      sample_count <= '0;
    end else if (done_accept) begin
      x_sample     <= X_i;
      y_sample     <= Y_i;
      z_sample     <= Z_i;
      sample_count <= sample_count + SAMPLE_COUNT_W'(1);
    end
  end

  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      retry <= '0;
    end else if ((state == ST_WAIT_DONE) && !Done_i && timeout_tick) begin
      retry <= retry + RETRY_W'(1);
    end else if (capture_pulse || (error_flag && Clear_Error_i)) begin
      retry <= '0;
    end
  end

  assign overrun_event = period_tick &&
                         (((state == ST_WAIT_TICK) && Busy_i) ||
                          (state == ST_START) ||
                          (state == ST_WAIT_DONE) ||
                          (state == ST_CAPTURE));

  // A new overrun in the clearing cycle wins so no event is lost.
  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      overrun <= 1'b0;
    end else if (overrun_event) begin
      overrun <= 1'b1;
    end else if (Clear_Error_i) begin
      overrun <= 1'b0;
    end
  end

  assign Start_o          = start_pulse;
  assign Data_Available_o = capture_pulse;
  assign Error_o          = error_flag;
  assign Overrun_o        = overrun;
  assign X_o              = x_sample;
  assign Y_o              = y_sample;
  assign Z_o              = z_sample;
  assign Sample_Count_o   = sample_count;

endmodule

`default_nettype wire

// File: tb/tb_adxl345_sample_scheduler.sv
// Scoreboard bench for adxl345_sample_scheduler: periodic sampling, timeout/retry, overrun, reset.
`default_nettype none

module tb_adxl345_sample_scheduler;

  localparam int PERIOD  = 100;
  localparam int TIMEOUT = 50;
  localparam int RETRIES = 3;
  localparam int AW      = 13;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 enable = 1'b0;
  logic                 clear_error = 1'b0;
  logic                 busy = 1'b0;
  logic                 done = 1'b0;
  logic signed [AW-1:0] x_in = '0;
  logic signed [AW-1:0] y_in = '0;
  logic signed [AW-1:0] z_in = '0;
  logic                 start;
  logic signed [AW-1:0] x_out;
  logic signed [AW-1:0] y_out;
  logic signed [AW-1:0] z_out;
  logic                 data_available;
  logic [15:0]          sample_count;
  logic                 error;
  logic                 overrun;

  adxl345_sample_scheduler #(
    .PERIOD_CYCLES  (PERIOD),
    .TIMEOUT_CYCLES (TIMEOUT),
    .MAX_RETRY      (RETRIES),
    .AXIS_W         (AW)
  ) dut (
    .Clk_i            (clk),
    .Reset_i          (rst),
    .Enable_i         (enable),
    .Clear_Error_i    (clear_error),
    .Start_o          (start),
    .Busy_i           (busy),
    .Done_i           (done),
    .X_i              (x_in),
    .Y_i              (y_in),
    .Z_i              (z_in),
    .X_o              (x_out),
    .Y_o              (y_out),
    .Z_o              (z_out),
    .Data_Available_o (data_available),
    .Sample_Count_o   (sample_count),
    .Error_o          (error),
    .Overrun_o        (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int z;
    int cnt;
    int due;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          da_seen = 0;
  int          start_seen = 0;
  logic [15:0] exp_count = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: pops the scoreboard on every Data_Available pulse.
  always @(negedge clk) begin
    if (start) start_seen++;
    if (data_available) begin
      da_seen++;
      chk("da_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("x_o", int'(x_out), e.x);
        chk("y_o", int'(y_out), e.y);
        chk("z_o", int'(z_out), e.z);
        chk("count", int'(sample_count), e.cnt);
        chk("latency", cyc, e.due);
      end
    end
  end

  task automatic wait_start(input int budget, output int s);
    int n;
    n = 0;
    s = -1;
    do begin
      @(negedge clk);
      n++;
    end while (!start && n < budget);
    if (start) s = cyc;
    else chk("start_seen", int'(start), 1);
  endtask

  task automatic wait_da(input int target, input int budget);
    int n;
    n = 0;
    while (da_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (da_seen < target) chk("da_wait", da_seen, target);
  endtask

  task automatic push_exp(input int x, input int y, input int z, input int due);
    exp_count = exp_count + 16'd1;
    sb.push_back('{x: x, y: y, z: z, cnt: int'(exp_count), due: due});
  endtask

  task automatic respond(input int delay, input int x, input int y, input int z);
    repeat (delay) @(negedge clk);
    done = 1'b1;
    x_in = AW'(x);
    y_in = AW'(y);
    z_in = AW'(z);
    @(negedge clk);
    done = 1'b0;
  endtask

  initial begin
    int s;
    int prev;
    int st0;
    int da0;

    repeat (3) @(negedge clk);
    chk("rst_start", int'(start), 0);
    chk("rst_da", int'(data_available), 0);
    chk("rst_count", int'(sample_count), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_ovr", int'(overrun), 0);
    chk("rst_x", int'(x_out), 0);
    rst = 1'b0;

    // Periodic sampling, Done 20 cycles after each Start.
    enable = 1'b1;
    prev = -1;
    for (int i = 0; i < 3; i++) begin
      wait_start(3 * PERIOD, s);
      if (prev >= 0) chk("period", s - prev, PERIOD);
      prev = s;
      push_exp(-5, 12, 256, s + 21);
      respond(20, -5, 12, 256);
    end
    enable = 1'b0;
    wait_da(3, 100);
    chk("ovr_a", int'(overrun), 0);
    repeat (5) @(negedge clk);

    // Done never arrives: two retries then ERROR.
    enable = 1'b1;
    wait_start(3 * PERIOD, prev);
    wait_start(3 * PERIOD, s);
    chk("retry1", s - prev, TIMEOUT + 1);
    prev = s;
    wait_start(3 * PERIOD, s);
    chk("retry2", s - prev, TIMEOUT + 1);
    repeat (TIMEOUT) @(negedge clk);
    chk("err_early", int'(error), 0);
    @(negedge clk);
    chk("err_set", int'(error), 1);
    st0 = start_seen;
    repeat (120) @(negedge clk);
    chk("err_nostart", start_seen - st0, 0);
    chk("ovr_b", int'(overrun), 1);
    enable = 1'b0;
    clear_error = 1'b1;
    @(negedge clk);
    clear_error = 1'b0;
    chk("err_clr", int'(error), 0);
    chk("ovr_clr", int'(overrun), 0);
    repeat (5) @(negedge clk);

    // Done coincides with the timeout terminal count.
    enable = 1'b1;
    wait_start(3 * PERIOD, s);
    @(negedge clk);
    st0 = start_seen;
    push_exp(100, -200, -1, s + TIMEOUT + 1);
    respond(TIMEOUT - 1, 100, -200, -1);
    enable = 1'b0;
    wait_da(4, 100);
    repeat (5) @(negedge clk);
    chk("tc_no_retry", start_seen - st0, 0);
    chk("tc_error", int'(error), 0);

    // Busy held across ticks: requests dropped, overrun flagged.
    busy = 1'b1;
    enable = 1'b1;
    st0 = start_seen;
    repeat (250) @(negedge clk);
    chk("busy_nostart", start_seen - st0, 0);
    chk("busy_ovr", int'(overrun), 1);
    chk("busy_error", int'(error), 0);
    enable = 1'b0;
    busy = 1'b0;
    @(negedge clk);
    clear_error = 1'b1;
    @(negedge clk);
    clear_error = 1'b0;
    chk("busy_ovr_clr", int'(overrun), 0);

    // Reset in WAIT_DONE, then a late Done.
    enable = 1'b1;
    wait_start(3 * PERIOD, s);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    chk("mid_rst_count", int'(sample_count), 0);
    chk("mid_rst_x", int'(x_out), 0);
    chk("mid_rst_start", int'(start), 0);
    rst = 1'b0;
    exp_count = '0;
    da0 = da_seen;
    respond(3, 7, 7, 7);
    repeat (30) @(negedge clk);
    chk("late_done_da", da_seen - da0, 0);
    chk("late_done_count", int'(sample_count), 0);
    chk("late_done_x", int'(x_out), 0);

    // Sample counter wrap from 0xFFFF.
    force dut.sample_count = 16'hFFFF;
    @(negedge clk);
    release dut.sample_count;
    @(negedge clk);
    chk("preload", int'(sample_count), 16'hFFFF);
    exp_count = 16'hFFFF;
    enable = 1'b1;
    wait_start(3 * PERIOD, s);
    push_exp(-4096, 4095, 0, s + 21);
    respond(20, -4096, 4095, 0);
    enable = 1'b0;
    wait_da(5, 100);
    repeat (5) @(negedge clk);
    chk("sb_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

endmodule

`default_nettype wire
